// File: rtl/rv_mem_pkg.sv
// Shared definitions for the RV32I/RV64I MEM stage.
// Contents: funct3 encodings for loads and stores, the memory-access FSM
// state type and the alignment check shared by the MEM-stage logic.
package rv_mem_pkg;

    // Load encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    // Store encodings
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;
    localparam logic [2:0] F3_SD  = 3'b011;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2
    } mem_state_e;

    // funct3[1:0] encodes the access size for loads and stores alike
    // (00 byte, 01 half, 10 word, 11 double).
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [2:0] addr);
        logic mis;
        case (funct3[1:0])
            2'b01:   mis = addr[0];
            2'b10:   mis = |addr[1:0];
            2'b11:   mis = |addr;
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/load_store_align.sv
// Combinational lane formatting for the MEM stage.
// Ports:
//   funct3_i      access size/sign
//   off_i         byte offset of the access inside the memory word
//   store_data_i  store data, right-justified
//   rsp_data_i    raw aligned word returned by memory
//   be_o          byte enables for a store
//   store_data_o  store data replicated across all lanes
//   load_data_o   addressed lane, sign/zero extended to XLEN
module load_store_align
    import rv_mem_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [2:0]        funct3_i,
    input  logic [OFF_W-1:0]  off_i,
    input  logic [XLEN-1:0]   store_data_i,
    input  logic [XLEN-1:0]   rsp_data_i,
    output logic [XLEN/8-1:0] be_o,
    output logic [XLEN-1:0]   store_data_o,
    output logic [XLEN-1:0]   load_data_o
);

    localparam int NB = XLEN / 8;

    // Response shifted so the addressed byte lands at bit 0.
    logic [XLEN-1:0] lane;
    assign lane = rsp_data_i >> {off_i, 3'b000};

    // Replicating the data into every lane lets memory pick it up with the
    // byte enables alone, whatever the offset.
    always_comb begin
        be_o         = '0;
        store_data_o = '0;
        case (funct3_i)
            F3_SB: begin
                be_o         = NB'(1) << off_i;
                store_data_o = {NB{store_data_i[7:0]}};
            end
            F3_SH: begin
                be_o         = NB'(3) << off_i;
                store_data_o = {(NB / 2){store_data_i[15:0]}};
            end
            F3_SW: begin
                be_o         = NB'(15) << off_i;
                store_data_o = {(NB / 4){store_data_i[31:0]}};
            end
            F3_SD: begin
                if (XLEN == 64) begin
                    be_o         = '1;
                    store_data_o = store_data_i;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        load_data_o = '0;
        case (funct3_i)
            F3_LB:  load_data_o = XLEN'($signed(lane[7:0]));
            F3_LH:  load_data_o = XLEN'($signed(lane[15:0]));
            F3_LW:  load_data_o = XLEN'($signed(lane[31:0]));
            F3_LBU: load_data_o = XLEN'(lane[7:0]);
            F3_LHU: load_data_o = XLEN'(lane[15:0]);
            F3_LWU: load_data_o = XLEN'(lane[31:0]);
            F3_LD: begin
                if (XLEN == 64) load_data_o = lane;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM stage of the RV32I/RV64I pipeline.
// Drives an external data memory through a valid/ready request channel and a
// valid-only response channel, formats store lanes and load extension, flags
// misaligned/illegal accesses, stalls IF..MEM while an access is pending and
// owns the MEM/WB pipeline register.
// Ports:
//   clk, reset (async, active-low)
//   *M inputs          MEM-stage instruction fields
//   FlushW             turn the next MEM/WB entry into a bubble
//   mem_req_*          request channel (valid/ready)
//   mem_rsp_*          response channel (valid only)
//   StallM, MemFaultM  hazard-unit controls
//   *W outputs         MEM/WB register contents
module mem_access_unit
    import rv_mem_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 10,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              RegWriteM,
    input  logic              MemReadM,
    input  logic              MemWriteM,
    input  logic [2:0]        WriteBackM,
    input  logic [2:0]        funct3M,
    input  logic [XLEN-1:0]   ALUResultM,
    input  logic [XLEN-1:0]   WriteDataM,
    input  logic [XLEN-1:0]   PCTargetM,
    input  logic [XLEN-1:0]   PCPlus4M,
    input  logic [XLEN-1:0]   ImmExtM,
    input  logic [RD_W-1:0]   RdM,
    input  logic              FlushW,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic              mem_req_we,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [XLEN-1:0]   mem_req_wdata,
    output logic [XLEN/8-1:0] mem_req_be,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_rdata,
    output logic              StallM,
    output logic              MemFaultM,
    output logic              RegWriteW,
    output logic [2:0]        WriteBackW,
    output logic [XLEN-1:0]   ALUResultW,
    output logic [XLEN-1:0]   ReadDataW,
    output logic [XLEN-1:0]   PCTargetW,
    output logic [XLEN-1:0]   ImmExtW,
    output logic [XLEN-1:0]   PCPlus4W,
    output logic [RD_W-1:0]   RdW
);

    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    mem_state_e        state_q, state_d;
    logic              access, illegal, fault, complete, req_valid, bubble;
    logic [NB-1:0]     be;
    logic [XLEN-1:0]   wdata, load_data;

    logic              RegWriteW_q;
    logic [2:0]        WriteBackW_q;
    logic [XLEN-1:0]   ALUResultW_q, ReadDataW_q, PCTargetW_q, ImmExtW_q, PCPlus4W_q;
    logic [RD_W-1:0]   RdW_q;

    load_store_align #(
        .XLEN  (XLEN),
        .OFF_W (OFF_W)
    ) u_align (
        .funct3_i     (funct3M),
        .off_i        (ALUResultM[OFF_W-1:0]),
        .store_data_i (WriteDataM),
        .rsp_data_i   (mem_rsp_rdata),
        .be_o         (be),
        .store_data_o (wdata),
        .load_data_o  (load_data)
    );

    assign access = MemReadM | MemWriteM;

    // Double-word encodings and LWU only exist on RV64.
    always_comb begin
        illegal = 1'b0;
        if (MemWriteM) begin
            illegal = funct3M[2] || (XLEN != 64 && funct3M == F3_SD);
        end else if (MemReadM) begin
            illegal = (funct3M == 3'b111) ||
                      (XLEN != 64 && (funct3M == F3_LD || funct3M == F3_LWU));
        end
    end

    assign fault = access & (illegal | is_misaligned(funct3M, ALUResultM[2:0]));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // complete marks the cycle in which the MEM instruction may leave the stage.
    always_comb begin
        state_d   = state_q;
        req_valid = 1'b0;
        complete  = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && !fault) begin
                    req_valid = 1'b1;
                    if (!mem_req_ready)  state_d  = REQ;
                    else if (MemWriteM)  complete = 1'b1;
                    else                 state_d  = WAIT_RSP;
                end
            end
            REQ: begin
                req_valid = 1'b1;
                if (mem_req_ready) begin
                    if (MemWriteM) begin
                        complete = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        state_d  = WAIT_RSP;
                    end
                end
            end
            WAIT_RSP: begin
                if (mem_rsp_valid) begin
                    complete = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are forced low while reset is held, independent of the M inputs.
    assign mem_req_valid = reset & req_valid;
    assign StallM        = reset & access & ~fault & ~complete;
    assign MemFaultM     = reset & (state_q == IDLE) & fault;
    assign mem_req_we    = mem_req_valid & MemWriteM;
    assign mem_req_addr  = mem_req_valid ? {ALUResultM[ADDR_W-1:OFF_W], OFF_W'(0)} : '0;
    assign mem_req_be    = mem_req_we ? be : '0;
    assign mem_req_wdata = mem_req_we ? wdata : '0;

    assign bubble = FlushW | StallM | MemFaultM;

    // MEM/WB register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWriteW_q  <= 1'b0;
            WriteBackW_q <= '0;
            ALUResultW_q <= '0;
            ReadDataW_q  <= '0;
            PCTargetW_q  <= '0;
            ImmExtW_q    <= '0;
            PCPlus4W_q   <= '0;
            RdW_q        <= '0;
        end else if (bubble) begin
            RegWriteW_q  <= 1'b0;
            WriteBackW_q <= '0;
            ALUResultW_q <= '0;
            ReadDataW_q  <= '0;
            PCTargetW_q  <= '0;
            ImmExtW_q    <= '0;
            PCPlus4W_q   <= '0;
            RdW_q        <= '0;
        end else begin
            RegWriteW_q  <= RegWriteM;
            WriteBackW_q <= WriteBackM;
            ALUResultW_q <= ALUResultM;
            ReadDataW_q  <= MemReadM ? load_data : '0;
            PCTargetW_q  <= PCTargetM;
            ImmExtW_q    <= ImmExtM;
            PCPlus4W_q   <= PCPlus4M;
            RdW_q        <= RdM;
        end
    end

    assign RegWriteW  = RegWriteW_q;
    assign WriteBackW = WriteBackW_q;
    assign ALUResultW = ALUResultW_q;
    assign ReadDataW  = ReadDataW_q;
    assign PCTargetW  = PCTargetW_q;
    assign ImmExtW    = ImmExtW_q;
    assign PCPlus4W   = PCPlus4W_q;
    assign RdW        = RdW_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

    localparam int XLEN   = 32;
    localparam int ADDR_W = 10;
    localparam int RD_W   = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              RegWriteM, MemReadM, MemWriteM, FlushW;
    logic [2:0]        WriteBackM, funct3M;
    logic [XLEN-1:0]   ALUResultM, WriteDataM, PCTargetM, PCPlus4M, ImmExtM;
    logic [RD_W-1:0]   RdM;
    logic              mem_req_valid, mem_req_ready, mem_req_we;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [XLEN-1:0]   mem_req_wdata;
    logic [XLEN/8-1:0] mem_req_be;
    logic              mem_rsp_valid;
    logic [XLEN-1:0]   mem_rsp_rdata;
    logic              StallM, MemFaultM, RegWriteW;
    logic [2:0]        WriteBackW;
    logic [XLEN-1:0]   ALUResultW, ReadDataW, PCTargetW, ImmExtW, PCPlus4W;
    logic [RD_W-1:0]   RdW;

    mem_access_unit #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RD_W(RD_W)) dut (
        .clk(clk), .reset(reset),
        .RegWriteM(RegWriteM), .MemReadM(MemReadM), .MemWriteM(MemWriteM),
        .WriteBackM(WriteBackM), .funct3M(funct3M), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .PCTargetM(PCTargetM), .PCPlus4M(PCPlus4M),
        .ImmExtM(ImmExtM), .RdM(RdM), .FlushW(FlushW),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_we(mem_req_we), .mem_req_addr(mem_req_addr),
        .mem_req_wdata(mem_req_wdata), .mem_req_be(mem_req_be),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata),
        .StallM(StallM), .MemFaultM(MemFaultM),
        .RegWriteW(RegWriteW), .WriteBackW(WriteBackW), .ALUResultW(ALUResultW),
        .ReadDataW(ReadDataW), .PCTargetW(PCTargetW), .ImmExtW(ImmExtW),
        .PCPlus4W(PCPlus4W), .RdW(RdW)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rw;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic [31:0] alu;
    } wrec_t;

    wrec_t wq[$];
    int vectors     = 0;
    int miscompares = 0;

    function automatic wrec_t w_now();
        w_now = {RegWriteW, RdW, ReadDataW, ALUResultW};
    endfunction

    task automatic drive_m(input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
                           input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] wd);
        RegWriteM  = rw;
        MemReadM   = mr;
        MemWriteM  = mw;
        funct3M    = f3;
        RdM        = rd;
        ALUResultM = addr;
        WriteDataM = wd;
        WriteBackM = 3'b001;
        PCTargetM  = 32'h100;
        PCPlus4M   = 32'h104;
        ImmExtM    = 32'h4;
    endtask

    task automatic test_reset();
        wrec_t obs;
        reset = 1'b0;
        FlushW = 1'b0;
        mem_req_ready = 1'b1;
        mem_rsp_valid = 1'b0;
        mem_rsp_rdata = '0;
        drive_m(1, 1, 0, 3'b010, 5'd3, 32'h8, 32'h0);
        repeat (2) @(negedge clk);
        obs = w_now();
        vectors++;
        if (obs !== '0 || WriteBackW !== 3'b0 || PCTargetW !== 32'h0 || PCPlus4W !== 32'h0 || ImmExtW !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_w got %h exp 0", obs);
        end
        vectors++;
        if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata, StallM, MemFaultM} !== '0) begin
            miscompares++;
            $display("FAIL reset_req valid=%b stall=%b fault=%b exp all 0", mem_req_valid, StallM, MemFaultM);
        end
        drive_m(0, 0, 0, 3'b0, 5'd0, 32'h0, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_lw_latency();
        int stalls = 0;
        wrec_t obs, exp;
        @(posedge clk); #1;
        drive_m(1, 1, 0, 3'b010, 5'd3, 32'h8, 32'h0);
        mem_req_ready = 1'b1;
        wq.push_back({1'b1, 5'd3, 32'hDEADBEEF, 32'h8});
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                mem_rsp_valid = 1'b1;
                mem_rsp_rdata = 32'hDEADBEEF;
            end
            @(negedge clk);
            if (c == 0) begin
                vectors++;
                if ({mem_req_valid, mem_req_we, mem_req_addr} !== {1'b1, 1'b0, 10'h8}) begin
                    miscompares++;
                    $display("FAIL lw_req got v=%b we=%b a=%h exp v=1 we=0 a=008", mem_req_valid, mem_req_we, mem_req_addr);
                end
            end
            if (StallM) stalls++;
            @(posedge clk); #1;
        end
        mem_rsp_valid = 1'b0;
        drive_m(0, 0, 0, 3'b0, 5'd0, 32'h0, 32'h0);
        vectors++;
        if (stalls != 3) begin
            miscompares++;
            $display("FAIL lw_stall_cycles got %0d exp 3", stalls);
        end
        exp = wq.pop_front();
        obs = w_now();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL lw_w got %h exp %h", obs, exp);
        end
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rdata;
        logic [31:0] res;
    } ld_t;

    task automatic test_load_extend();
        ld_t tab[$];
        wrec_t obs, exp;
        tab.push_back('{3'b000, 32'h0B, 32'h80FFFF7F, 32'hFFFFFF80});
        tab.push_back('{3'b100, 32'h0B, 32'h80FFFF7F, 32'h00000080});
        tab.push_back('{3'b000, 32'h08, 32'h80FFFF7F, 32'h0000007F});
        tab.push_back('{3'b001, 32'h0A, 32'h80FFFF7F, 32'hFFFF80FF});
        tab.push_back('{3'b101, 32'h0A, 32'h80FFFF7F, 32'h000080FF});
        tab.push_back('{3'b001, 32'h04, 32'h12348001, 32'hFFFF8001});
        tab.push_back('{3'b010, 32'h0C, 32'h76543210, 32'h76543210});
        foreach (tab[i]) begin
            @(posedge clk); #1;
            drive_m(1, 1, 0, tab[i].f3, 5'(i + 1), tab[i].addr, 32'h0);
            mem_req_ready = 1'b1;
            wq.push_back({1'b1, 5'(i + 1), tab[i].res, tab[i].addr});
            @(negedge clk);
            vectors++;
            if ({mem_req_valid, mem_req_addr, StallM} !== {1'b1, tab[i].addr[9:2], 2'b00, 1'b1}) begin
                miscompares++;
                $display("FAIL ld%0d_req got v=%b a=%h s=%b exp v=1 a=%h s=1", i, mem_req_valid, mem_req_addr, StallM, {tab[i].addr[9:2], 2'b00});
            end
            @(posedge clk); #1;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rsp_rdata = tab[i].rdata;
            @(negedge clk);
            vectors++;
            if (StallM !== 1'b0) begin
                miscompares++;
                $display("FAIL ld%0d_rsp_stall got %b exp 0", i, StallM);
            end
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            drive_m(0, 0, 0, 3'b0, 5'd0, 32'h0, 32'h0);
            exp = wq.pop_front();
            obs = w_now();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL ld%0d_w got %h exp %h", i, obs, exp);
            end
        end
    endtask

    task automatic test_store_backpressure();
        int stalls = 0;
        wrec_t obs, exp;
        @(posedge clk); #1;
        drive_m(0, 0, 1, 3'b001, 5'd0, 32'h6, 32'h00001234);
        mem_req_ready = 1'b0;
        wq.push_back({1'b0, 5'd0, 32'h0, 32'h6});
        for (int c = 0; c < 3; c++) begin
            if (c == 2) mem_req_ready = 1'b1;
            @(negedge clk);
            vectors++;
            if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata} !==
                {1'b1, 1'b1, 10'h4, 4'b1100, 32'h12341234}) begin
                miscompares++;
                $display("FAIL sh_req%0d got v=%b we=%b a=%h be=%b d=%h exp v=1 we=1 a=004 be=1100 d=12341234",
                         c, mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata);
            end
            if (StallM) stalls++;
            @(posedge clk); #1;
        end
        mem_req_ready = 1'b0;
        drive_m(0, 0, 0, 3'b0, 5'd0, 32'h0, 32'h0);
        vectors++;
        if (stalls != 2) begin
            miscompares++;
            $display("FAIL sh_stall_cycles got %0d exp 2", stalls);
        end
        exp = wq.pop_front();
        obs = w_now();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL sh_w got %h exp %h", obs, exp);
        end
    endtask

    typedef struct {
        logic        mr;
        logic        mw;
        logic [2:0]  f3;
        logic [31:0] addr;
    } flt_t;

    task automatic test_fault();
        flt_t tab[$];
        wrec_t obs, exp;
        tab.push_back('{1'b1, 1'b0, 3'b010, 32'h02});
        tab.push_back('{1'b0, 1'b1, 3'b001, 32'h03});
        tab.push_back('{1'b1, 1'b0, 3'b111, 32'h00});
        tab.push_back('{1'b0, 1'b1, 3'b100, 32'h00});
        tab.push_back('{1'b1, 1'b0, 3'b011, 32'h00});
        mem_req_ready = 1'b1;
        foreach (tab[i]) begin
            @(posedge clk); #1;
            drive_m(tab[i].mr, tab[i].mr, tab[i].mw, tab[i].f3, 5'd7, tab[i].addr, 32'h55);
            wq.push_back('0);
            @(negedge clk);
            vectors++;
            if ({mem_req_valid, MemFaultM, StallM} !== 3'b010) begin
                miscompares++;
                $display("FAIL flt%0d_ctl got v=%b f=%b s=%b exp v=0 f=1 s=0", i, mem_req_valid, MemFaultM, StallM);
            end
            @(posedge clk); #1;
            drive_m(0, 0, 0, 3'b0, 5'd0, 32'h0, 32'h0);
            exp = wq.pop_front();
            obs = w_now();
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL flt%0d_w got %h exp %h", i, obs, exp);
            end
            @(negedge clk);
            vectors++;
            if (MemFaultM !== 1'b0) begin
                miscompares++;
                $display("FAIL flt%0d_pulse got %b exp 0", i, MemFaultM);
            end
        end
        mem_req_ready = 1'b0;
    endtask

    task automatic test_reset_flush();
        wrec_t obs, exp;
        @(posedge clk); #1;
        drive_m(1, 1, 0, 3'b010, 5'd5, 32'h10, 32'h0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({mem_req_valid, StallM} !== 2'b11) begin
            miscompares++;
            $display("FAIL rst_req got v=%b s=%b exp v=1 s=1", mem_req_valid, StallM);
        end
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        obs = w_now();
        vectors++;
        if (obs !== '0 || {mem_req_valid, StallM} !== 2'b00) begin
            miscompares++;
            $display("FAIL rst_mid got w=%h v=%b s=%b exp w=0 v=0 s=0", obs, mem_req_valid, StallM);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        drive_m(0, 0, 0, 3'b0, 5'd0, 32'h0, 32'h0);
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        // Stale response still present: a fresh load must be seen from IDLE.
        drive_m(1, 1, 0, 3'b010, 5'd9, 32'h14, 32'h0);
        @(negedge clk);
        vectors++;
        if ({mem_req_valid, StallM} !== 2'b11) begin
            miscompares++;
            $display("FAIL rst_idle got v=%b s=%b exp v=1 s=1", mem_req_valid, StallM);
        end
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if ({mem_req_valid, StallM} !== 2'b11) begin
            miscompares++;
            $display("FAIL flush_req got v=%b s=%b exp v=1 s=1", mem_req_valid, StallM);
        end
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rsp_rdata = 32'h00000055;
        FlushW = 1'b1;
        wq.push_back('0);
        @(negedge clk);
        vectors++;
        if (StallM !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_stall got %b exp 0", StallM);
        end
        @(posedge clk); #1;
        FlushW = 1'b0;
        mem_rsp_valid = 1'b0;
        exp = wq.pop_front();
        obs = w_now();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL flush_w got %h exp %h", obs, exp);
        end
        drive_m(0, 0, 1, 3'b010, 5'd0, 32'h18, 32'hA5A5A5A5);
        mem_req_ready = 1'b1;
        wq.push_back({1'b0, 5'd0, 32'h0, 32'h18});
        @(negedge clk);
        vectors++;
        if ({mem_req_valid, StallM} !== 2'b10) begin
            miscompares++;
            $display("FAIL flush_after got v=%b s=%b exp v=1 s=0", mem_req_valid, StallM);
        end
        @(posedge clk); #1;
        drive_m(0, 0, 0, 3'b0, 5'd0, 32'h0, 32'h0);
        mem_req_ready = 1'b0;
        exp = wq.pop_front();
        obs = w_now();
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL flush_after_w got %h exp %h", obs, exp);
        end
    endtask

    typedef struct {
        logic        rw;
        logic        mw;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [47:0] req;  // {valid, we, addr[9:0], be, wdata}
    } bb_t;

    task automatic test_back_to_back();
        bb_t tab[$];
        wrec_t obs, exp;
        int stalls = 0;
        tab.push_back('{1'b0, 1'b1, 3'b010, 5'd0,  32'h20, 32'hCAFEBABE, {1'b1, 1'b1, 10'h20, 4'b1111, 32'hCAFEBABE}});
        tab.push_back('{1'b0, 1'b1, 3'b010, 5'd0,  32'h24, 32'h01020304, {1'b1, 1'b1, 10'h24, 4'b1111, 32'h01020304}});
        tab.push_back('{1'b0, 1'b1, 3'b000, 5'd0,  32'h05, 32'h000000AB, {1'b1, 1'b1, 10'h04, 4'b0010, 32'hABABABAB}});
        tab.push_back('{1'b0, 1'b1, 3'b001, 5'd0,  32'h02, 32'h0000BEEF, {1'b1, 1'b1, 10'h00, 4'b1100, 32'hBEEFBEEF}});
        tab.push_back('{1'b1, 1'b0, 3'b000, 5'd12, 32'h1234, 32'h0,      48'h0});
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        drive_m(tab[0].rw, 1'b0, tab[0].mw, tab[0].f3, tab[0].rd, tab[0].addr, tab[0].wd);
        wq.push_back({tab[0].rw, tab[0].rd, 32'h0, tab[0].addr});
        for (int i = 0; i < tab.size(); i++) begin
            @(negedge clk);
            vectors++;
            if ({mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata} !== tab[i].req) begin
                miscompares++;
                $display("FAIL b2b%0d_req got %h exp %h", i,
                         {mem_req_valid, mem_req_we, mem_req_addr, mem_req_be, mem_req_wdata}, tab[i].req);
            end
            if (StallM) stalls++;
            @(posedge clk); #1;
            exp = wq.pop_front();
            obs = w_now();
            if (i + 1 < tab.size()) begin
                drive_m(tab[i+1].rw, 1'b0, tab[i+1].mw, tab[i+1].f3, tab[i+1].rd, tab[i+1].addr, tab[i+1].wd);
                wq.push_back({tab[i+1].rw, tab[i+1].rd, 32'h0, tab[i+1].addr});
            end else begin
                drive_m(0, 0, 0, 3'b0, 5'd0, 32'h0, 32'h0);
            end
            vectors++;
            if (obs !== exp) begin
                miscompares++;
                $display("FAIL b2b%0d_w got %h exp %h", i, obs, exp);
            end
        end
        vectors++;
        if (stalls != 0) begin
            miscompares++;
            $display("FAIL b2b_stalls got %0d exp 0", stalls);
        end
        mem_req_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_lw_latency();
        test_load_extend();
        test_store_backpressure();
        test_fault();
        test_reset_flush();
        test_back_to_back();
        @(posedge clk); #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
